mem_bus_arbiter: RTL

Shares the single-port program/data memory between two requesters.
- Requester 0 (fetch) is driven by the fetch stage of control_fsm.
- Requester 1 (data) is driven by the exec/writeback stage for loads and stores.
- The block sequences each access over a fixed memory latency and returns a one-cycle ack with read data.
- It resolves simultaneous requests: data has priority, with a starvation bound that protects fetch.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_arb_pick.sv | 17 +
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant IDs and counter widths.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic GNT_F = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int LAT_W    = 4;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational grant selection: data wins a tie unless fetch has hit its starvation bound.
module arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic starve_hit,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = f_req | d_req;
    grant = (d_req && !(f_req && starve_hit)) ? GNT_D : GNT_F;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single-port memory: IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ack).
// Handshake: req/addr/wdata/we are sampled only on the IDLE grant edge; the ack is a one-cycle pulse.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_e            dbg_state
);

  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_e                state_q;
  logic [LAT_W-1:0]      lat_cnt_q;
  logic [STARVE_W-1:0]   starve_cnt_q;
  logic                  gnt_q;
  logic                  mem_en_q, mem_we_q, f_ack_q, d_ack_q, busy_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q, f_rdata_q, d_rdata_q;

  logic starve_hit, pick_valid, pick_grant;

  assign starve_hit = (starve_cnt_q == STARVE_LIM);

  arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      gnt_q        <= GNT_F;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            state_q   <= S_ACCESS;
            gnt_q     <= pick_grant;
            lat_cnt_q <= LAT_INIT;
            mem_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            if (pick_grant == GNT_D) begin
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_we_q    <= d_we;
              // A data win only counts against fetch if fetch was actually waiting.
              if (f_req && !starve_hit) starve_cnt_q <= starve_cnt_q + 1'b1;
            end else begin
              mem_addr_q   <= f_addr;
              mem_wdata_q  <= '0;
              mem_we_q     <= 1'b0;
              starve_cnt_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (lat_cnt_q == '0) begin
            state_q  <= S_DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gnt_q == GNT_F) begin
              f_rdata_q <= mem_rdata;
              f_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= mem_rdata;
              d_ack_q <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
